// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit bus bridge.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_DONE
    } lsu_state_e;

    localparam logic [2:0] WIDTH_BYTE   = 3'b000;
    localparam logic [2:0] WIDTH_HALF   = 3'b001;
    localparam logic [2:0] WIDTH_WORD   = 3'b010;
    localparam logic [2:0] WIDTH_BYTE_U = 3'b100;
    localparam logic [2:0] WIDTH_HALF_U = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

    function automatic logic is_byte(input logic [2:0] width);
        return (width == WIDTH_BYTE) || (width == WIDTH_BYTE_U);
    endfunction

    function automatic logic is_half(input logic [2:0] width);
        return (width == WIDTH_HALF) || (width == WIDTH_HALF_U);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store-data replication,
// load-data right shift and misalignment detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_width,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_rsp_offset,
    input  logic [31:0] i_rsp_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    // Unlisted width encodings fall through to word behaviour.
    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_misaligned = (i_offset != 2'b00);
        if (is_byte(i_width)) begin
            o_be         = 4'b0001 << i_offset;
            o_wdata      = {4{i_wdata[7:0]}};
            o_misaligned = 1'b0;
        end else if (is_half(i_width)) begin
            o_be         = 4'b0011 << {i_offset[1], 1'b0};
            o_wdata      = {2{i_wdata[15:0]}};
            o_misaligned = i_offset[0];
        end
    end

    assign o_rdata = i_rsp_rdata >> {i_rsp_offset, 3'b000};

endmodule

// File: rtl/lsu_bus_bridge.sv
// MEM-stage load/store to valid/ready bus bridge with response capture,
// misalignment reporting and a request/response timeout.
module lsu_bus_bridge
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] alu_result_mem_i,
    input  logic [31:0] write_data_mem_i,
    input  logic [2:0]  width_src_mem_i,
    input  logic        mem_write_mem_i,
    input  logic        mem_read_mem_i,
    input  logic        hold_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic        req_we_o,
    output logic [31:0] req_addr_o,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    input  logic        rsp_valid_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] read_data_mem_o,
    output logic        stall_mem_o,
    output logic        misaligned_o,
    output logic        bus_error_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_valid;
    logic             r_req_we;
    logic [31:0]      r_req_addr;
    logic [3:0]       r_req_be;
    logic [31:0]      r_req_wdata;
    logic [1:0]       r_rsp_off;
    logic [31:0]      r_rdata;
    logic             r_misaligned;
    logic             r_bus_error;

    logic             w_access;
    logic             w_issue;
    logic             w_expire;
    logic             w_misaligned;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rdata;

    lsu_align u_align (
        .i_offset     (alu_result_mem_i[1:0]),
        .i_width      (width_src_mem_i),
        .i_wdata      (write_data_mem_i),
        .i_rsp_offset (r_rsp_off),
        .i_rsp_rdata  (rsp_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_rdata),
        .o_misaligned (w_misaligned)
    );

    assign w_access = mem_write_mem_i || mem_read_mem_i;
    assign w_issue  = (r_state == ST_IDLE) && w_access && !w_misaligned;
    assign w_expire = (r_cnt >= CNT_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_req_valid  <= 1'b0;
            r_req_we     <= 1'b0;
            r_req_addr   <= '0;
            r_req_be     <= '0;
            r_req_wdata  <= '0;
            r_rsp_off    <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access && w_misaligned) begin
                        r_misaligned <= 1'b1;
                    end else if (w_access) begin
                        // A simultaneous read and write is issued as a store.
                        r_req_valid <= 1'b1;
                        r_req_we    <= mem_write_mem_i;
                        r_req_addr  <= {alu_result_mem_i[31:2], 2'b00};
                        r_req_be    <= w_be;
                        r_req_wdata <= w_wdata;
                        r_rsp_off   <= alu_result_mem_i[1:0];
                        r_cnt       <= '0;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_ready_i) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= r_cnt + 1'b1;
                        r_state     <= r_req_we ? ST_DONE : ST_WAIT_RSP;
                    end else if (w_expire) begin
                        r_req_valid <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_rdata     <= '0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_RSP: begin
                    if (rsp_valid_i) begin
                        r_rdata <= w_rdata;
                        r_state <= ST_DONE;
                    end else if (w_expire) begin
                        r_bus_error <= 1'b1;
                        r_rdata     <= '0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!hold_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall_mem_o     = reset_ni && ((r_state == ST_REQ) || (r_state == ST_WAIT_RSP) || w_issue);
    assign req_valid_o     = r_req_valid;
    assign req_we_o        = r_req_we;
    assign req_addr_o      = r_req_addr;
    assign req_be_o        = r_req_be;
    assign req_wdata_o     = r_req_wdata;
    assign read_data_mem_o = r_rdata;
    assign misaligned_o    = r_misaligned;
    assign bus_error_o     = r_bus_error;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Randomised transaction-level bench for lsu_bus_bridge with per-cycle
// comparison against a timeline model and literal-pinned directed cases.
module tb_lsu_bus_bridge;

    localparam int unsigned T = 8;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [31:0] alu_result_mem_i;
    logic [31:0] write_data_mem_i;
    logic [2:0]  width_src_mem_i;
    logic        mem_write_mem_i;
    logic        mem_read_mem_i;
    logic        hold_i;
    logic        req_valid_o;
    logic        req_ready_i;
    logic        req_we_o;
    logic [31:0] req_addr_o;
    logic [3:0]  req_be_o;
    logic [31:0] req_wdata_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_rdata_i;
    logic [31:0] read_data_mem_o;
    logic        stall_mem_o;
    logic        misaligned_o;
    logic        bus_error_o;

    always #5 clk_i = ~clk_i;

    lsu_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .alu_result_mem_i (alu_result_mem_i),
        .write_data_mem_i (write_data_mem_i),
        .width_src_mem_i  (width_src_mem_i),
        .mem_write_mem_i  (mem_write_mem_i),
        .mem_read_mem_i   (mem_read_mem_i),
        .hold_i           (hold_i),
        .req_valid_o      (req_valid_o),
        .req_ready_i      (req_ready_i),
        .req_we_o         (req_we_o),
        .req_addr_o       (req_addr_o),
        .req_be_o         (req_be_o),
        .req_wdata_o      (req_wdata_o),
        .rsp_valid_i      (rsp_valid_i),
        .rsp_rdata_i      (rsp_rdata_i),
        .read_data_mem_o  (read_data_mem_o),
        .stall_mem_o      (stall_mem_o),
        .misaligned_o     (misaligned_o),
        .bus_error_o      (bus_error_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        chk_en   = 1'b0;

    // Expected outputs for the current cycle.
    logic        e_stall, e_valid, e_we, e_mis, e_berr, mis_next;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;

    int unsigned stall_cnt = 0, valid_cnt = 0, mis_cnt = 0, berr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("stall", 32'(stall_mem_o), 32'(e_stall));
            chk("req_valid", 32'(req_valid_o), 32'(e_valid));
            chk("req_we", 32'(req_we_o), 32'(e_we));
            chk("req_addr", req_addr_o, e_addr);
            chk("req_be", 32'(req_be_o), 32'(e_be));
            chk("req_wdata", req_wdata_o, e_wdata);
            chk("read_data", read_data_mem_o, e_rdata);
            chk("misaligned", 32'(misaligned_o), 32'(e_mis));
            chk("bus_error", 32'(bus_error_o), 32'(e_berr));
        end
        if (stall_mem_o === 1'b1)  stall_cnt++;
        if (req_valid_o === 1'b1)  valid_cnt++;
        if (misaligned_o === 1'b1) mis_cnt++;
        if (bus_error_o === 1'b1)  berr_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Width classes: 0 byte, 1 half, 2 word.
    function automatic int unsigned wclass(input logic [2:0] w);
        if (w == 3'b000 || w == 3'b100) return 0;
        if (w == 3'b001 || w == 3'b101) return 1;
        return 2;
    endfunction

    function automatic logic mis_model(input logic [2:0] w, input int unsigned off);
        if (wclass(w) == 1) return (off % 2) != 0;
        if (wclass(w) == 2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] be_model(input logic [2:0] w, input int unsigned off);
        if (wclass(w) == 0) return 4'(1 << off);
        if (wclass(w) == 1) return 4'(3 << ((off / 2) * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] wd_model(input logic [2:0] w, input logic [31:0] wd);
        if (wclass(w) == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (wclass(w) == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
        e_mis    = mis_next;
        mis_next = 1'b0;
        e_berr   = 1'b0;
        e_stall  = 1'b0;
        e_valid  = 1'b0;
        mem_write_mem_i  = 1'b0;
        mem_read_mem_i   = 1'b0;
        alu_result_mem_i = $urandom;
        write_data_mem_i = $urandom;
        width_src_mem_i  = 3'($urandom);
        req_ready_i      = 1'($urandom);
        rsp_valid_i      = 1'($urandom);
        rsp_rdata_i      = $urandom;
        hold_i           = 1'($urandom);
    endtask

    task automatic settle();
        #6;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] w,
                         input logic st, input logic ld);
        alu_result_mem_i = a;
        write_data_mem_i = wd;
        width_src_mem_i  = w;
        mem_write_mem_i  = st;
        mem_read_mem_i   = ld;
    endtask

    // One MEM-stage access: d_r REQ cycles before ready, d_s WAIT cycles before
    // response, h extra DONE cycles under hold. Timeline counted from REQ entry.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] w,
                           input logic st, input logic ld, input int unsigned d_r,
                           input int unsigned d_s, input int unsigned h, input logic [31:0] rd);
        int unsigned off, k, j;
        logic        err, in_req, done;
        logic [31:0] new_rdata;
        off = int'(a[1:0]);
        k = 0; j = 0; err = 1'b0; in_req = 1'b1; done = 1'b0;
        new_rdata = e_rdata;
        step();
        drive(a, wd, w, st, ld);
        if (mis_model(w, off)) begin
            hold_i   = 1'b0;
            mis_next = 1'b1;
            return;
        end
        e_stall = 1'b1;
        while (!done) begin
            step();
            drive(a, wd, w, st, ld);
            e_stall = 1'b1;
            if (k == 0) begin
                e_addr  = a & 32'hFFFF_FFFC;
                e_be    = be_model(w, off);
                e_wdata = wd_model(w, wd);
                e_we    = st;
            end
            if (in_req) begin
                e_valid = 1'b1;
                if (k == d_r) begin
                    req_ready_i = 1'b1;
                    if (st) done = 1'b1;
                    else in_req = 1'b0;
                end else begin
                    req_ready_i = 1'b0;
                    if (k >= T - 1) begin err = 1'b1; done = 1'b1; end
                end
            end else begin
                rsp_valid_i = (j == d_s);
                if (j == d_s) begin
                    rsp_rdata_i = rd;
                    new_rdata   = rd >> (8 * off);
                    done        = 1'b1;
                end else if (k >= T - 1) begin
                    err = 1'b1; done = 1'b1;
                end
                j++;
            end
            k++;
        end
        if (err) new_rdata = 32'h0;
        step();
        drive(a, wd, w, st, ld);
        e_berr  = err;
        e_rdata = new_rdata;
        hold_i  = (h > 0);
        for (int unsigned i = 1; i <= h; i++) begin
            step();
            drive(a, wd, w, st, ld);
            hold_i = (i < h);
        end
    endtask

    initial begin
        int unsigned s_stall, s_valid, s_mis, s_berr;
        logic [2:0]  wtab [5];
        wtab[0] = 3'b000; wtab[1] = 3'b001; wtab[2] = 3'b010; wtab[3] = 3'b100; wtab[4] = 3'b101;

        reset_ni = 1'b0;
        alu_result_mem_i = '0; write_data_mem_i = '0; width_src_mem_i = '0;
        mem_write_mem_i = 1'b0; mem_read_mem_i = 1'b0; hold_i = 1'b0;
        req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_rdata_i = '0;
        e_stall = 0; e_valid = 0; e_we = 0; e_mis = 0; e_berr = 0; mis_next = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_be = '0;
        chk_en = 1'b1;

        repeat (3) begin
            step();
            mem_read_mem_i = 1'b1; alu_result_mem_i = 32'h0; width_src_mem_i = 3'b010;
        end
        settle();
        chk("reset_stall", 32'(stall_mem_o), 32'h0);
        chk("reset_valid", 32'(req_valid_o), 32'h0);
        step();
        reset_ni = 1'b1;
        step();
        settle();

        // sb 0x103
        s_stall = stall_cnt;
        run_txn(32'h103, 32'h0000_00AB, 3'b000, 1'b1, 1'b0, 0, 0, 0, 32'h0);
        settle();
        chk("sb_be", 32'(req_be_o), 32'h8);
        chk("sb_wdata", req_wdata_o, 32'hABAB_ABAB);
        chk("sb_addr", req_addr_o, 32'h100);
        chk("sb_stall_cycles", stall_cnt - s_stall, 32'd2);

        // lw 0x200, response after 4 wait cycles
        run_txn(32'h200, 32'h0, 3'b010, 1'b0, 1'b1, 0, 4, 2, 32'hDEAD_BEEF);
        settle();
        chk("lw_rdata", read_data_mem_o, 32'hDEAD_BEEF);
        chk("lw_done_stall", 32'(stall_mem_o), 32'h0);

        // lhu 0x202
        run_txn(32'h202, 32'h0, 3'b101, 1'b0, 1'b1, 1, 0, 0, 32'h1234_5678);
        settle();
        chk("lhu_rdata", read_data_mem_o, 32'h0000_1234);
        chk("lhu_be", 32'(req_be_o), 32'hC);

        // sw 0x201 misaligned
        s_stall = stall_cnt; s_valid = valid_cnt; s_mis = mis_cnt;
        run_txn(32'h201, 32'h5555_AAAA, 3'b010, 1'b1, 1'b0, 0, 0, 0, 32'h0);
        step();
        step();
        settle();
        chk("mis_no_valid", valid_cnt - s_valid, 32'd0);
        chk("mis_no_stall", stall_cnt - s_stall, 32'd0);
        chk("mis_pulses", mis_cnt - s_mis, 32'd1);

        // lw with ready never asserted -> timeout
        s_stall = stall_cnt; s_berr = berr_cnt;
        run_txn(32'h400, 32'h0, 3'b010, 1'b0, 1'b1, 100, 0, 0, 32'h0);
        settle();
        chk("to_berr_pulses", berr_cnt - s_berr, 32'd1);
        chk("to_stall_cycles", stall_cnt - s_stall, 32'd9);
        chk("to_rdata", read_data_mem_o, 32'h0);
        chk("to_done_stall", 32'(stall_mem_o), 32'h0);

        for (int unsigned n = 0; n < 300; n++) begin
            logic [31:0] a;
            int unsigned kind;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
            kind = $urandom_range(0, 2);
            run_txn(a, $urandom, wtab[$urandom_range(0, 4)], kind != 1, kind != 0,
                    $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 2), $urandom);
            repeat ($urandom_range(0, 2)) step();
        end

        // reset while waiting for a load response
        step();
        drive(32'h300, 32'h1111_2222, 3'b010, 1'b0, 1'b1);
        e_stall = 1'b1;
        step();
        drive(32'h300, 32'h1111_2222, 3'b010, 1'b0, 1'b1);
        e_stall = 1'b1; e_valid = 1'b1; req_ready_i = 1'b1;
        e_addr = 32'h300; e_be = 4'hF; e_wdata = 32'h1111_2222; e_we = 1'b0;
        step();
        drive(32'h300, 32'h1111_2222, 3'b010, 1'b0, 1'b1);
        e_stall = 1'b1; rsp_valid_i = 1'b0;
        step();
        reset_ni = 1'b0;
        drive(32'h300, 32'h1111_2222, 3'b010, 1'b0, 1'b1);
        rsp_valid_i = 1'b0;
        e_addr = '0; e_be = '0; e_wdata = '0; e_we = 1'b0; e_rdata = '0;
        settle();
        chk("rst_mid_stall", 32'(stall_mem_o), 32'h0);
        chk("rst_mid_valid", 32'(req_valid_o), 32'h0);
        step();
        reset_ni = 1'b1;
        rsp_valid_i = 1'b1; rsp_rdata_i = 32'hCAFE_F00D;
        repeat (3) begin
            step();
            rsp_valid_i = 1'b1; rsp_rdata_i = 32'hCAFE_F00D;
        end
        settle();
        chk("late_rsp_rdata", read_data_mem_o, 32'h0);
        chk("late_rsp_stall", 32'(stall_mem_o), 32'h0);

        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_bus_bridge.md
LSU_BUS_BRIDGE -- requirements
Module: lsu_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles in REQ+WAIT_RSP before bus error.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port alu_result_mem_i  input  32  MEM-stage byte address.
REQ-005 SHALL have port write_data_mem_i  input  32  MEM-stage store data, unaligned.
REQ-006 SHALL have port width_src_mem_i  input  3  access width: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-007 SHALL have port mem_write_mem_i / mem_read_mem_i  input  1 each  store / load in MEM.
REQ-008 SHALL have port hold_i  input  1  pipeline stall from sources other than this block.
REQ-009 SHALL have ports req_valid_o  output  1, req_ready_i  input  1, req_we_o  output  1, req_addr_o  output  32 (word-aligned), req_be_o  output  4, req_wdata_o  output  32.
REQ-010 SHALL have ports rsp_valid_i  input  1, rsp_rdata_i  input  32  load response.
REQ-011 SHALL have port read_data_mem_o  output  32  load word shifted right by 8*addr[1:0], zero-filled.
REQ-012 SHALL have ports stall_mem_o, misaligned_o, bus_error_o  output  1 each.

Function
REQ-013 SHALL implement FSM IDLE, REQ, WAIT_RSP, DONE.
REQ-014 IDLE with aligned access pending SHALL register addr/be/wdata/we, go REQ, assert stall_mem_o combinationally same cycle.
REQ-015 REQ SHALL hold req_valid_o=1 and all req_* stable until req_valid_o&&req_ready_i.
REQ-016 Store handshake SHALL go DONE; load handshake SHALL go WAIT_RSP.
REQ-017 WAIT_RSP SHALL capture aligned rsp_rdata_i into read_data_mem_o on rsp_valid_i, go DONE; rsp_valid_i outside WAIT_RSP ignored.
REQ-018 stall_mem_o SHALL be 1 in REQ and WAIT_RSP, and in IDLE with aligned access pending; 0 in DONE.
REQ-019 DONE SHALL return to IDLE when hold_i=0, stay while hold_i=1, never reissue the request.
REQ-020 Byte enables: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111.
REQ-021 wdata: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
REQ-022 Misaligned (half addr[0]=1; word addr[1:0]!=0) SHALL issue no request, pulse misaligned_o one cycle, no stall, stay IDLE.
REQ-023 Simultaneous mem_write and mem_read SHALL be treated as store.
REQ-024 Timeout counter SHALL clear on entering REQ, increment in REQ/WAIT_RSP; reaching TIMEOUT_CYCLES SHALL pulse bus_error_o, set read_data_mem_o=0, go DONE.
REQ-025 Load-to-DONE latency SHALL be 1 cycle after rsp_valid_i; minimum access 3 cycles (IDLE, REQ, DONE) with req_ready_i=1.

Reset
REQ-026 reset_ni=0 SHALL asynchronously force IDLE, req_valid_o=0, req_we_o=0, req_addr_o=0, req_be_o=0, req_wdata_o=0, read_data_mem_o=0, misaligned_o=0, bus_error_o=0, counter=0.
REQ-027 Reset mid-transaction SHALL abandon it; late rsp_valid_i after reset SHALL be ignored.
REQ-028 stall_mem_o SHALL be 0 during reset.

Structure
REQ-029 lsu_pkg SHALL hold state enum, width_src encodings, default TIMEOUT_CYCLES.
REQ-030 SHALL instantiate one combinational sub-module lsu_align (be, wdata replicate, read shift, misaligned detect).

Verification
REQ-031 sb addr 0x103, wd 0x000000AB, ready=1 -> req_be_o=1000, req_wdata_o=0xABABABAB, req_addr_o=0x100, stall 2 cycles.
REQ-032 lw addr 0x200, rsp 0xDEADBEEF after 4 wait cycles -> read_data_mem_o=0xDEADBEEF, stall_mem_o low in DONE.
REQ-033 lhu addr 0x202, rsp 0x12345678 -> read_data_mem_o=0x00001234, req_be_o=1100.
REQ-034 sw addr 0x201 -> no req_valid_o, misaligned_o pulse 1 cycle, stall_mem_o=0.
REQ-035 lw, req_ready_i=0, TIMEOUT_CYCLES=8 -> bus_error_o pulse after 8 cycles, read_data_mem_o=0, DONE.
REQ-036 reset_ni=0 in WAIT_RSP, later rsp_valid_i=1 -> IDLE, all outputs 0, response ignored.
